// File: rtl/coin_lane_scheduler_if.sv
// Frame-sync, game-state and per-lane coin signals between the coin scheduler and
// the rest of the penguin runner.
interface coin_lane_scheduler_if;
  logic        i_v_sync;
  logic        i_enable;
  logic [1:0]  i_penguin_lane;
  logic [15:0] o_coin_y_left;
  logic [15:0] o_coin_y_center;
  logic [15:0] o_coin_y_right;
  logic [2:0]  o_coin_active;
  logic [15:0] o_score;
  logic [2:0]  o_collect_pulse;
  logic [2:0]  o_miss_pulse;

  modport slave (
    input  i_v_sync, i_enable, i_penguin_lane,
    output o_coin_y_left, o_coin_y_center, o_coin_y_right,
    output o_coin_active, o_score, o_collect_pulse, o_miss_pulse
  );

  modport master (
    output i_v_sync, i_enable, i_penguin_lane,
    input  o_coin_y_left, o_coin_y_center, o_coin_y_right,
    input  o_coin_active, o_score, o_collect_pulse, o_miss_pulse
  );
endinterface

// File: rtl/coin_lane_scheduler.sv
// Three-lane coin controller: frame tick from v_sync, LFSR-driven spawning,
// per-lane depth FSMs, collection scoring and miss detection.
module coin_lane_scheduler #(
  parameter int unsigned Y_END       = 592,
  parameter int unsigned SCORE_Y_MIN = 500,
  parameter int unsigned GAP_MIN     = 60,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input logic                  i_clk,
  input logic                  i_rst,
  coin_lane_scheduler_if.slave bus
);

  localparam logic [15:0] YEnd     = 16'(Y_END);
  localparam logic [15:0] ScoreMin = 16'(SCORE_Y_MIN);
  localparam logic [6:0]  GapMin   = 7'(GAP_MIN);

  typedef enum logic [1:0] {StIdle, StFall, StCollected} lane_state_e;

  logic          sync1_q, sync2_q, sync3_q;
  logic          tick;
  logic          act;
  logic [15:0]   lfsr_q, lfsr_d, lfsr_next;
  logic [6:0]    gap_q, gap_d, gap_dec;
  lane_state_e   state_q [3];
  lane_state_e   state_d [3];
  logic [15:0]   y_q [3];
  logic [15:0]   y_d [3];
  logic [2:0]    active_q, active_d;
  logic [15:0]   score_q, score_d;
  logic [2:0]    collect_q, collect_d;
  logic [2:0]    miss_q, miss_d;
  logic          hit;
  logic [1:0]    sel;

  assign tick      = sync2_q & ~sync3_q;
  assign act       = tick & bus.i_enable;
  assign lfsr_next = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign sel       = lfsr_next[1:0];
  assign gap_dec   = (gap_q == 7'd0) ? 7'd0 : gap_q - 7'd1;

  always_comb begin
    lfsr_d    = lfsr_q;
    gap_d     = gap_q;
    score_d   = score_q;
    active_d  = active_q;
    collect_d = 3'b000;
    miss_d    = 3'b000;
    hit       = 1'b0;
    for (int k = 0; k < 3; k++) begin
      state_d[k] = state_q[k];
      y_d[k]     = y_q[k];
    end

    if (act) begin
      lfsr_d = lfsr_next;
      for (int k = 0; k < 3; k++) begin
        unique case (state_q[k])
          StFall: begin
            // Collection is judged on the pre-increment depth.
            if (y_q[k] > ScoreMin && y_q[k] < YEnd && bus.i_penguin_lane == 2'(k)) begin
              state_d[k]   = StCollected;
              collect_d[k] = 1'b1;
              hit          = 1'b1;
            end else if (y_q[k] + 16'd1 == YEnd) begin
              state_d[k] = StIdle;
              y_d[k]     = 16'd0;
              miss_d[k]  = 1'b1;
            end else begin
              y_d[k] = y_q[k] + 16'd1;
            end
          end
          StCollected: begin
            state_d[k] = StIdle;
            y_d[k]     = 16'd0;
          end
          default: begin
            state_d[k] = StIdle;
            y_d[k]     = 16'd0;
          end
        endcase
      end

      if (hit && score_q != 16'hFFFF) begin
        score_d = score_q + 16'd1;
      end

      // Spawn sees lane states after this tick's update; sel==3 retries next tick.
      gap_d = gap_dec;
      if (gap_dec == 7'd0 && sel != 2'd3) begin
        gap_d = GapMin + {1'b0, lfsr_next[7:2]};
        for (int k = 0; k < 3; k++) begin
          if (sel == 2'(k) && state_d[k] == StIdle) begin
            state_d[k] = StFall;
            y_d[k]     = 16'd0;
          end
        end
      end

      for (int k = 0; k < 3; k++) begin
        active_d[k] = (state_d[k] == StFall);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      sync3_q   <= 1'b0;
      lfsr_q    <= LFSR_SEED;
      gap_q     <= GapMin;
      active_q  <= 3'b000;
      score_q   <= 16'd0;
      collect_q <= 3'b000;
      miss_q    <= 3'b000;
      for (int k = 0; k < 3; k++) begin
        state_q[k] <= StIdle;
        y_q[k]     <= 16'd0;
      end
    end else begin
      sync1_q   <= bus.i_v_sync;
      sync2_q   <= sync1_q;
      sync3_q   <= sync2_q;
      lfsr_q    <= lfsr_d;
      gap_q     <= gap_d;
      active_q  <= active_d;
      score_q   <= score_d;
      collect_q <= collect_d;
      miss_q    <= miss_d;
      for (int k = 0; k < 3; k++) begin
        state_q[k] <= state_d[k];
        y_q[k]     <= y_d[k];
      end
    end
  end

  assign bus.o_coin_y_left   = y_q[0];
  assign bus.o_coin_y_center = y_q[1];
  assign bus.o_coin_y_right  = y_q[2];
  assign bus.o_coin_active   = active_q;
  assign bus.o_score         = score_q;
  assign bus.o_collect_pulse = collect_q;
  assign bus.o_miss_pulse    = miss_q;

endmodule

// File: tb/tb_coin_lane_scheduler.sv
// Randomized frame-level bench for coin_lane_scheduler against a per-frame
// behavioural model of lanes, spawn gap, LFSR and score.
module tb_coin_lane_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  coin_lane_scheduler_if bus ();

  coin_lane_scheduler dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  int          m_y[3];
  bit          m_fall[3];
  bit          m_coll[3];
  int          m_gap;
  logic [15:0] m_lfsr;
  int          m_score;
  int          exp_coll[3];
  int          exp_miss[3];
  int          obs_coll[3];
  int          obs_miss[3];

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    logic fb;
    fb = v[15] ^ v[13] ^ v[12] ^ v[10];
    return {v[14:0], fb};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_y[k] = 0;
      m_fall[k] = 0;
      m_coll[k] = 0;
    end
    m_gap = 60;
    m_lfsr = 16'hACE1;
    m_score = 0;
  endtask

  task automatic model_tick(input int pl);
    int s;
    m_lfsr = lfsr_step(m_lfsr);
    for (int k = 0; k < 3; k++) begin
      if (m_coll[k]) begin
        m_coll[k] = 0;
        m_y[k] = 0;
      end else if (m_fall[k]) begin
        if (m_y[k] > 500 && m_y[k] < 592 && pl == k) begin
          m_fall[k] = 0;
          m_coll[k] = 1;
          if (m_score < 65535) m_score++;
          exp_coll[k]++;
        end else if (m_y[k] + 1 == 592) begin
          m_fall[k] = 0;
          m_y[k] = 0;
          exp_miss[k]++;
        end else begin
          m_y[k]++;
        end
      end
    end
    if (m_gap > 0) m_gap--;
    if (m_gap == 0) begin
      s = int'(m_lfsr) % 4;
      if (s != 3) begin
        if (!m_fall[s] && !m_coll[s]) begin
          m_fall[s] = 1;
          m_y[s] = 0;
        end
        m_gap = 60 + (int'(m_lfsr) / 4) % 64;
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 3; k++) begin
        obs_coll[k] += int'(bus.o_collect_pulse[k]);
        obs_miss[k] += int'(bus.o_miss_pulse[k]);
      end
    end
  end

  task automatic frame();
    @(negedge clk) bus.i_v_sync = 1'b1;
    repeat (4) @(negedge clk);
    bus.i_v_sync = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic check_all();
    check("active", int'(bus.o_coin_active),
          int'(m_fall[0]) + 2 * int'(m_fall[1]) + 4 * int'(m_fall[2]));
    check("y_left", int'(bus.o_coin_y_left), m_y[0]);
    check("y_center", int'(bus.o_coin_y_center), m_y[1]);
    check("y_right", int'(bus.o_coin_y_right), m_y[2]);
    check("score", int'(bus.o_score), m_score);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("collect_cnt%0d", k), obs_coll[k], exp_coll[k]);
      check($sformatf("miss_cnt%0d", k), obs_miss[k], exp_miss[k]);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_active"}, int'(bus.o_coin_active), 0);
    check({tag, "_yl"}, int'(bus.o_coin_y_left), 0);
    check({tag, "_yc"}, int'(bus.o_coin_y_center), 0);
    check({tag, "_yr"}, int'(bus.o_coin_y_right), 0);
    check({tag, "_score"}, int'(bus.o_score), 0);
    check({tag, "_pulses"}, int'({bus.o_collect_pulse, bus.o_miss_pulse}), 0);
  endtask

  initial begin
    int pl;
    int dis_left;
    int total_coll;
    bus.i_v_sync = 1'b0;
    bus.i_enable = 1'b0;
    bus.i_penguin_lane = 2'd3;
    for (int k = 0; k < 3; k++) begin
      exp_coll[k] = 0;
      exp_miss[k] = 0;
      obs_coll[k] = 0;
      obs_miss[k] = 0;
    end
    model_reset();
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    rst = 1'b0;

    // First 60 ticks: nothing may spawn before the 60th.
    bus.i_enable = 1'b1;
    pl = 3;
    for (int f = 0; f < 60; f++) begin
      frame();
      model_tick(pl);
      check_all();
    end

    dis_left = 0;
    for (int f = 0; f < 3000; f++) begin
      if (f == 1500) begin
        @(posedge clk);
        #3 rst = 1'b1;
        #1 check_zero_outputs("midreset");
        model_reset();
        @(negedge clk) rst = 1'b0;
      end
      if (f % 50 == 0) pl = $urandom_range(0, 3);
      for (int k = 0; k < 3; k++) begin
        if (m_fall[k] && m_y[k] >= 490 && m_y[k] <= 505 && ($urandom % 2) == 0) pl = k;
      end
      bus.i_penguin_lane = 2'(pl);
      if (dis_left > 0) begin
        bus.i_enable = 1'b0;
        dis_left--;
      end else if (($urandom % 60) == 0) begin
        bus.i_enable = 1'b0;
        dis_left = $urandom_range(0, 99);
      end else begin
        bus.i_enable = 1'b1;
      end
      frame();
      if (bus.i_enable) model_tick(pl);
      check_all();
    end

    total_coll = exp_coll[0] + exp_coll[1] + exp_coll[2];
    if (total_coll == 0) $display("note: no collections occurred in this run");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/coin_lane_scheduler.md
Name: coin_lane_scheduler

Overview:
- Central controller for the three perspective coin lanes (left, center, right) in the penguin runner.
- Runs on the pixel clock and derives a one-cycle frame tick from v_sync.
- Decides pseudo-randomly when and in which lane a coin spawns, and advances each coin's depth coordinate once per frame.
- Detects collection against the penguin lane, counts score, and drives the y coordinate and active flag consumed by the per-lane coin sprite renderers.

Parameters:
- Y_END, 592: depth at which a falling coin is retired as missed (720-128).
- SCORE_Y_MIN, 500: a coin is collectable only while y > SCORE_Y_MIN and y < Y_END.
- GAP_MIN, 60: minimum frames between spawn attempts.
- LFSR_SEED, 16'hACE1: reset value of the spawn LFSR; must be nonzero.

Ports:
- i_clk, input, 1: pixel clock.
- i_rst, input, 1: asynchronous active-high reset.
- i_v_sync, input, 1: raw vertical sync, asynchronous to logic; rising edge marks a frame.
- i_enable, input, 1: game running; when low, ticks are ignored.
- i_penguin_lane, input, 2: 0=left, 1=center, 2=right, 3=none/airborne.
- o_coin_y_left, output, 16: left coin depth.
- o_coin_y_center, output, 16: center coin depth.
- o_coin_y_right, output, 16: right coin depth.
- o_coin_active, output, 3: bit0 left, bit1 center, bit2 right; renderer draws only when set.
- o_score, output, 16: collected coin count, saturating.
- o_collect_pulse, output, 3: one-clock pulse per lane on collection.
- o_miss_pulse, output, 3: one-clock pulse per lane on reaching Y_END uncollected.

Behaviour:
- Reset (async, any time, including mid-frame):
  - All lanes go to IDLE; all o_coin_y = 0.
  - o_coin_active = 0, o_score = 0, pulses = 0.
  - LFSR = LFSR_SEED; gap counter = GAP_MIN; synchronizer flops = 0.
- Frame tick:
  - i_v_sync passes through a 2-flop synchronizer, then a rising-edge detect.
  - tick is one i_clk cycle, 3 clocks after the raw rising edge.
  - A tick is acted on only when i_enable = 1. When i_enable = 0, all state is frozen (positions, gap counter, LFSR) and no pulses are generated.
- Per acted tick, in order:
  - The LFSR advances once (16-bit Fibonacci, taps 16,14,13,11, shift left, feedback into bit0).
  - Lanes update.
  - Spawn logic is evaluated using the post-advance LFSR value.
- Lane FSM (identical per lane, index k):
  - IDLE: active = 0, y = 0. Enters FALL only via spawn.
  - FALL: active = 1. Each tick, y <= y+1.
    - If, before incrementing, y > SCORE_Y_MIN, y < Y_END and i_penguin_lane == k: go to COLLECTED, pulse collect[k] on the tick cycle, score += 1 (held at 16'hFFFF), y holds.
    - Else, if y+1 == Y_END: go to IDLE, pulse miss[k], y = 0.
  - COLLECTED: active = 0, y held. The next acted tick goes to IDLE with y = 0. A coin cannot be collected twice.
- Spawn logic:
  - The gap counter decrements per acted tick while nonzero.
  - When it is 0, lane sel = LFSR[1:0].
    - If sel == 3, no spawn is attempted and the counter stays 0, so a retry happens next tick.
    - If sel < 3 and lane sel is IDLE (after this tick's lane update), it enters FALL with y = 0. The gap counter reloads to GAP_MIN + LFSR[7:2] (range GAP_MIN..GAP_MIN+63).
    - If sel < 3 but lane sel is not IDLE, the spawn is dropped and the counter reloads the same way.
  - At most one spawn per tick.
  - A lane retiring to IDLE and being spawned on the same tick is legal: y restarts at 0 and active stays 1.
- Arithmetic:
  - y is a 16-bit unsigned value and never exceeds Y_END-1.
  - Gap counter is 7 bits.
  - Score increments at most once per tick, since only one lane can match i_penguin_lane.
- Outputs are registered. Pulses are high for exactly the one clock following the tick cycle.
- Glitches on i_v_sync shorter than 2 clocks may be missed; this is acceptable.

Test Plan:
- Reset then i_enable=1, 60 v_sync edges -> no spawn before tick 60; on tick 60, the lane chosen from the stepped seed LFSR goes active with y=0.
- Force a spawn in center with i_penguin_lane=3, then 592 ticks -> y reaches 591, miss_pulse[1] fires for one clock, active[1]=0, score stays 0.
- Center coin falling, i_penguin_lane=1 from y=495 -> collect on the tick with y=501, score=1, exactly one collect_pulse; COLLECTED then IDLE on the next tick.
- i_penguin_lane=1 only while y=500, then 3 -> no collect (boundary is strict), later miss.
- i_enable=0 for 100 v_sync edges mid-fall at y=200 -> y stays 200, gap counter and LFSR unchanged; resumes at 201 on the first enabled tick.
- Assert i_rst at y=550 with score=5 -> immediately all active=0, y=0, score=0; after release, the first spawn again occurs 60 ticks later with the identical seed sequence.
